// File: rtl/intr_sequencer_if.sv
// Control bus between the main MCU and the interrupt sequencer.
interface intr_sequencer_if;
  // Requests from the MCU
  logic        INTR;
  logic        FLAGS_IE;
  logic        BOUNDARY;
  logic        RETI_REQ;
  // Sequencer status and handshakes
  logic        BUSY;
  logic        DONE;
  logic        INTA;
  logic        IE_CLR;
  logic        FLAGS_LD;
  logic        PC_LD;
  logic [1:0]  PC_SRC;
  logic [31:0] PC_VEC;
  // Datapath control fields
  logic [4:0]  FS;
  logic        D_En;
  logic        S_Sel;
  logic        T_Sel;
  logic        HILO_ld;
  logic [1:0]  DA_sel;
  logic [1:0]  D_Sel;
  logic [2:0]  Y_Sel;
  logic [31:0] DT;
  logic        DM_CS;
  logic        DM_WR;
  logic        DM_RD;

  // MCU side
  modport master (
    output INTR, FLAGS_IE, BOUNDARY, RETI_REQ,
    input  BUSY, DONE, INTA, IE_CLR, FLAGS_LD, PC_LD, PC_SRC, PC_VEC,
    input  FS, D_En, S_Sel, T_Sel, HILO_ld, DA_sel, D_Sel, Y_Sel, DT,
    input  DM_CS, DM_WR, DM_RD
  );

  // Sequencer side
  modport slave (
    input  INTR, FLAGS_IE, BOUNDARY, RETI_REQ,
    output BUSY, DONE, INTA, IE_CLR, FLAGS_LD, PC_LD, PC_SRC, PC_VEC,
    output FS, D_En, S_Sel, T_Sel, HILO_ld, DA_sel, D_Sel, Y_Sel, DT,
    output DM_CS, DM_WR, DM_RD
  );
endinterface

// File: rtl/intr_sequencer.sv
// Interrupt entry / RETI microsequencer. Moore FSM whose control outputs
// are registered from the next state, so they always match the current state.
module intr_sequencer (
  input logic            CLK,
  input logic            RESET,
  intr_sequencer_if.slave bus
);
  localparam int unsigned ST_W   = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned FS_W   = 5;

  localparam logic [FS_W-1:0]   FS_PASS = 5'h00;
  localparam logic [FS_W-1:0]   FS_ADD  = 5'h02;
  localparam logic [FS_W-1:0]   FS_SUB  = 5'h03;
  localparam logic [DATA_W-1:0] VECTOR  = 32'h0000_0200;

  localparam logic [ST_W-1:0] ST_IDLE   = 5'd0;
  localparam logic [ST_W-1:0] ST_E_RD1  = 5'd1;
  localparam logic [ST_W-1:0] ST_E_ALU1 = 5'd2;
  localparam logic [ST_W-1:0] ST_E_WR1  = 5'd3;
  localparam logic [ST_W-1:0] ST_E_RD2  = 5'd4;
  localparam logic [ST_W-1:0] ST_E_ALU2 = 5'd5;
  localparam logic [ST_W-1:0] ST_E_WR2  = 5'd6;
  localparam logic [ST_W-1:0] ST_E_VEC  = 5'd7;
  localparam logic [ST_W-1:0] ST_R_RD1  = 5'd8;
  localparam logic [ST_W-1:0] ST_R_ALU1 = 5'd9;
  localparam logic [ST_W-1:0] ST_R_MEM1 = 5'd10;
  localparam logic [ST_W-1:0] ST_R_RD2  = 5'd11;
  localparam logic [ST_W-1:0] ST_R_ALU2 = 5'd12;
  localparam logic [ST_W-1:0] ST_R_MEM2 = 5'd13;
  localparam logic [ST_W-1:0] ST_R_PC   = 5'd14;
  localparam logic [ST_W-1:0] ST_R_ALU3 = 5'd15;
  localparam logic [ST_W-1:0] ST_R_WR3  = 5'd16;

  logic [ST_W-1:0]   state;
  logic [ST_W-1:0]   nxt;

  logic              busy_n;
  logic              done_n;
  logic              inta_n;
  logic              ie_clr_n;
  logic              flags_ld_n;
  logic              pc_ld_n;
  logic [1:0]        pc_src_n;
  logic [FS_W-1:0]   fs_n;
  logic              d_en_n;
  logic              s_sel_n;
  logic              t_sel_n;
  logic [1:0]        da_sel_n;
  logic [1:0]        d_sel_n;
  logic [2:0]        y_sel_n;
  logic [DATA_W-1:0] dt_n;
  logic              dm_cs_n;
  logic              dm_wr_n;
  logic              dm_rd_n;

  assign bus.PC_VEC  = VECTOR;
  assign bus.HILO_ld = 1'b0;

  // Next-state selection and control decode of the state about to be entered
  always_comb begin
    nxt        = ST_IDLE;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    inta_n     = 1'b0;
    ie_clr_n   = 1'b0;
    flags_ld_n = 1'b0;
    pc_ld_n    = 1'b0;
    pc_src_n   = 2'd0;
    fs_n       = FS_PASS;
    d_en_n     = 1'b0;
    s_sel_n    = 1'b0;
    t_sel_n    = 1'b0;
    da_sel_n   = 2'd0;
    d_sel_n    = 2'd0;
    y_sel_n    = 3'd0;
    dt_n       = '0;
    dm_cs_n    = 1'b0;
    dm_wr_n    = 1'b0;
    dm_rd_n    = 1'b0;

    case (state)
      ST_IDLE: begin
        // RETI has priority; requests are only looked at here
        if (bus.RETI_REQ)
          nxt = ST_R_RD1;
        else if (bus.BOUNDARY && bus.INTR && bus.FLAGS_IE)
          nxt = ST_E_RD1;
        else
          nxt = ST_IDLE;
      end
      ST_E_RD1:  nxt = ST_E_ALU1;
      ST_E_ALU1: nxt = ST_E_WR1;
      ST_E_WR1:  nxt = ST_E_RD2;
      ST_E_RD2:  nxt = ST_E_ALU2;
      ST_E_ALU2: nxt = ST_E_WR2;
      ST_E_WR2:  nxt = ST_E_VEC;
      ST_E_VEC:  nxt = ST_IDLE;
      ST_R_RD1:  nxt = ST_R_ALU1;
      ST_R_ALU1: nxt = ST_R_MEM1;
      ST_R_MEM1: nxt = ST_R_RD2;
      ST_R_RD2:  nxt = ST_R_ALU2;
      ST_R_ALU2: nxt = ST_R_MEM2;
      ST_R_MEM2: nxt = ST_R_PC;
      ST_R_PC:   nxt = ST_R_ALU3;
      ST_R_ALU3: nxt = ST_R_WR3;
      ST_R_WR3:  nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase

    busy_n = (nxt != ST_IDLE);

    case (nxt)
      ST_E_RD1, ST_E_RD2, ST_R_RD2: begin
        s_sel_n = 1'b1;
        t_sel_n = 1'b1;
        dt_n    = 32'd4;
      end
      ST_R_RD1: begin
        s_sel_n = 1'b1;
        t_sel_n = 1'b1;
        dt_n    = 32'd0;
      end
      ST_E_ALU1, ST_E_ALU2: fs_n = FS_SUB;
      ST_R_ALU1, ST_R_ALU2, ST_R_ALU3: fs_n = FS_ADD;
      ST_E_WR1, ST_E_WR2: begin
        // Store PC (first push) or flags (second push) and write back $sp
        da_sel_n = 2'd3;
        d_en_n   = 1'b1;
        d_sel_n  = (nxt == ST_E_WR1) ? 2'd1 : 2'd2;
        dm_cs_n  = 1'b1;
        dm_wr_n  = 1'b1;
      end
      ST_E_VEC: begin
        pc_ld_n  = 1'b1;
        pc_src_n = 2'd1;
        ie_clr_n = 1'b1;
        inta_n   = 1'b1;
        done_n   = 1'b1;
      end
      ST_R_MEM1: begin
        s_sel_n    = 1'b1;
        dm_cs_n    = 1'b1;
        dm_rd_n    = 1'b1;
        flags_ld_n = 1'b1;
      end
      ST_R_MEM2: begin
        dm_cs_n = 1'b1;
        dm_rd_n = 1'b1;
      end
      ST_R_PC: begin
        // Popped PC goes out through Y_Sel while $sp+8 is set up
        y_sel_n  = 3'd2;
        pc_ld_n  = 1'b1;
        pc_src_n = 2'd2;
        s_sel_n  = 1'b1;
        t_sel_n  = 1'b1;
        dt_n     = 32'd8;
      end
      ST_R_WR3: begin
        da_sel_n = 2'd3;
        d_en_n   = 1'b1;
        done_n   = 1'b1;
      end
      default: ;
    endcase
  end

  // State and registered control outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_IDLE;
      bus.BUSY     <= 1'b0;
      bus.DONE     <= 1'b0;
      bus.INTA     <= 1'b0;
      bus.IE_CLR   <= 1'b0;
      bus.FLAGS_LD <= 1'b0;
      bus.PC_LD    <= 1'b0;
      bus.PC_SRC   <= 2'd0;
      bus.FS       <= FS_PASS;
      bus.D_En     <= 1'b0;
      bus.S_Sel    <= 1'b0;
      bus.T_Sel    <= 1'b0;
      bus.DA_sel   <= 2'd0;
      bus.D_Sel    <= 2'd0;
      bus.Y_Sel    <= 3'd0;
      bus.DT       <= '0;
      bus.DM_CS    <= 1'b0;
      bus.DM_WR    <= 1'b0;
      bus.DM_RD    <= 1'b0;
    end else begin
      state        <= nxt;
      bus.BUSY     <= busy_n;
      bus.DONE     <= done_n;
      bus.INTA     <= inta_n;
      bus.IE_CLR   <= ie_clr_n;
      bus.FLAGS_LD <= flags_ld_n;
      bus.PC_LD    <= pc_ld_n;
      bus.PC_SRC   <= pc_src_n;
      bus.FS       <= fs_n;
      bus.D_En     <= d_en_n;
      bus.S_Sel    <= s_sel_n;
      bus.T_Sel    <= t_sel_n;
      bus.DA_sel   <= da_sel_n;
      bus.D_Sel    <= d_sel_n;
      bus.Y_Sel    <= y_sel_n;
      bus.DT       <= dt_n;
      bus.DM_CS    <= dm_cs_n;
      bus.DM_WR    <= dm_wr_n;
      bus.DM_RD    <= dm_rd_n;
    end
  end
endmodule

// File: tb/tb_intr_sequencer.sv
// Bench for intr_sequencer: vector table, directed multi-cycle sequences
// with a small stack/datapath model, and random requests against a step model.
module tb_intr_sequencer;
  localparam logic [4:0]  FS_PASS = 5'h00;
  localparam logic [4:0]  FS_ADD  = 5'h02;
  localparam logic [4:0]  FS_SUB  = 5'h03;
  localparam logic [31:0] VECTOR  = 32'h0000_0200;

  logic clk;
  logic rst;
  intr_sequencer_if bus ();

  intr_sequencer dut (.CLK(clk), .RESET(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy, done, inta, ie_clr, flags_ld, pc_ld;
    logic [1:0]  pc_src;
    logic [4:0]  fs;
    logic        d_en, s_sel, t_sel, hilo_ld;
    logic [1:0]  da_sel, d_sel;
    logic [2:0]  y_sel;
    logic [31:0] dt;
    logic        dm_cs, dm_wr, dm_rd;
    logic [31:0] pc_vec;
  } ctl_t;

  typedef struct {
    logic reti, intr, boundary, ie;
    int   kind;  // 0 stays idle, 1 entry, 2 RETI
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Datapath / stack model driven by the sequencer's controls
  logic [31:0] sp, pc, rs, rt, alu_reg, din_reg, alu_out;
  logic [4:0]  flags;
  logic [31:0] mem [0:1023];
  logic        ld_en, mem_ld_en;
  logic [31:0] ld_sp, ld_pc, mem_ld_addr, mem_ld_data;
  logic [4:0]  ld_flags;

  assign alu_out = (bus.Y_Sel == 3'd2) ? din_reg : alu_reg;

  always @(posedge clk) begin
    if (ld_en) begin
      sp    <= ld_sp;
      pc    <= ld_pc;
      flags <= ld_flags;
    end else begin
      if (bus.S_Sel) rs <= sp;
      if (bus.T_Sel) rt <= bus.DT;
      if (bus.FS == FS_ADD) alu_reg <= rs + rt;
      else if (bus.FS == FS_SUB) alu_reg <= rs - rt;
      if (bus.DM_CS && bus.DM_WR)
        mem[alu_reg[11:2]] <= (bus.D_Sel == 2'd1) ? pc : {27'd0, flags};
      if (bus.DM_CS && bus.DM_RD) din_reg <= mem[alu_reg[11:2]];
      if (bus.FLAGS_LD) flags <= mem[alu_reg[11:2]][4:0];
      else if (bus.IE_CLR) flags[4] <= 1'b0;
      if (bus.PC_LD) begin
        if (bus.PC_SRC == 2'd1) pc <= bus.PC_VEC;
        else if (bus.PC_SRC == 2'd2) pc <= alu_out;
      end
      if (bus.D_En && bus.DA_sel == 2'd3) sp <= alu_reg;
    end
    if (mem_ld_en) mem[mem_ld_addr[11:2]] <= mem_ld_data;
  end

  function automatic ctl_t sample();
    ctl_t c;
    c.busy = bus.BUSY;     c.done = bus.DONE;     c.inta = bus.INTA;
    c.ie_clr = bus.IE_CLR; c.flags_ld = bus.FLAGS_LD; c.pc_ld = bus.PC_LD;
    c.pc_src = bus.PC_SRC; c.fs = bus.FS;         c.d_en = bus.D_En;
    c.s_sel = bus.S_Sel;   c.t_sel = bus.T_Sel;   c.hilo_ld = bus.HILO_ld;
    c.da_sel = bus.DA_sel; c.d_sel = bus.D_Sel;   c.y_sel = bus.Y_Sel;
    c.dt = bus.DT;         c.dm_cs = bus.DM_CS;   c.dm_wr = bus.DM_WR;
    c.dm_rd = bus.DM_RD;   c.pc_vec = bus.PC_VEC;
    return c;
  endfunction

  // Expected controls for step 1..N of a sequence, straight from the state table
  function automatic ctl_t exp_ctl(int kind, int step);
    ctl_t c;
    c = '0;
    c.fs = FS_PASS;
    c.pc_vec = VECTOR;
    if (kind == 0) return c;
    c.busy = 1'b1;
    if (kind == 1) begin
      case (step)
        1, 4: begin c.s_sel = 1; c.t_sel = 1; c.dt = 32'd4; end
        2, 5: c.fs = FS_SUB;
        3, 6: begin
          c.da_sel = 2'd3; c.d_en = 1; c.dm_cs = 1; c.dm_wr = 1;
          c.d_sel = (step == 3) ? 2'd1 : 2'd2;
        end
        7: begin c.pc_ld = 1; c.pc_src = 2'd1; c.ie_clr = 1; c.inta = 1; c.done = 1; end
        default: ;
      endcase
    end else begin
      case (step)
        1: begin c.s_sel = 1; c.t_sel = 1; c.dt = 32'd0; end
        2, 5, 8: c.fs = FS_ADD;
        3: begin c.s_sel = 1; c.dm_cs = 1; c.dm_rd = 1; c.flags_ld = 1; end
        4: begin c.s_sel = 1; c.t_sel = 1; c.dt = 32'd4; end
        6: begin c.dm_cs = 1; c.dm_rd = 1; end
        7: begin
          c.y_sel = 3'd2; c.pc_ld = 1; c.pc_src = 2'd2;
          c.s_sel = 1; c.t_sel = 1; c.dt = 32'd8;
        end
        9: begin c.da_sel = 2'd3; c.d_en = 1; c.done = 1; end
        default: ;
      endcase
    end
    return c;
  endfunction

  task automatic check_ctl(input string name, input ctl_t exp);
    ctl_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: controls got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.INTR = 0; bus.BOUNDARY = 0; bus.FLAGS_IE = 0; bus.RETI_REQ = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic preload(input logic [31:0] s, input logic [31:0] p, input logic [4:0] f);
    ld_sp = s; ld_pc = p; ld_flags = f; ld_en = 1;
    @(negedge clk);
    ld_en = 0;
  endtask

  task automatic mem_load(input logic [31:0] a, input logic [31:0] d);
    mem_ld_addr = a; mem_ld_data = d; mem_ld_en = 1;
    @(negedge clk);
    mem_ld_en = 0;
  endtask

  vec_t vecs [8];
  int   m_kind, m_step;

  initial begin
    rst = 1; ld_en = 0; mem_ld_en = 0;
    ld_sp = 0; ld_pc = 0; ld_flags = 0; mem_ld_addr = 0; mem_ld_data = 0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    check_ctl("reset_idle", exp_ctl(0, 0));
    rst = 0;

    // One-cycle request vectors from IDLE: which sequence starts, if any
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 2};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 2};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 2};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      bus.RETI_REQ = vecs[i].reti; bus.INTR = vecs[i].intr;
      bus.BOUNDARY = vecs[i].boundary; bus.FLAGS_IE = vecs[i].ie;
      @(negedge clk);
      clear_inputs();
      check_ctl($sformatf("vec%0d", i), exp_ctl(vecs[i].kind, 1));
    end

    // Reset held two cycles while in E_ALU1
    do_reset();
    bus.INTR = 1; bus.BOUNDARY = 1; bus.FLAGS_IE = 1;
    @(negedge clk);
    bus.INTR = 0;
    check_ctl("rst_mid_rd1", exp_ctl(1, 1));
    @(negedge clk);
    check_ctl("rst_mid_alu1", exp_ctl(1, 2));
    rst = 1;
    @(negedge clk);
    check_ctl("rst_mid_hold1", exp_ctl(0, 0));
    @(negedge clk);
    rst = 0;
    check_ctl("rst_mid_hold2", exp_ctl(0, 0));
    @(negedge clk);
    check_ctl("rst_mid_after", exp_ctl(0, 0));

    // Entry: push PC and flags, load vector
    do_reset();
    preload(32'h3FC, 32'h100, 5'h1F);
    bus.INTR = 1; bus.BOUNDARY = 1; bus.FLAGS_IE = 1;
    @(negedge clk);
    bus.INTR = 0;
    for (int k = 1; k <= 7; k++) begin
      check_ctl($sformatf("entry_c%0d", k), exp_ctl(1, k));
      @(negedge clk);
    end
    check_ctl("entry_idle", exp_ctl(0, 0));
    check_val("entry_mem_pc", mem[10'h3F8 >> 2], 32'h100);
    check_val("entry_mem_flags", {27'd0, mem[10'h3F4 >> 2][4:0]}, 32'h1F);
    check_val("entry_sp", sp, 32'h3F4);
    check_val("entry_pc", pc, VECTOR);

    // RETI: pop flags then PC, restore $sp
    preload(32'h3F4, 32'h200, 5'h00);
    mem_load(32'h3F4, 32'h0F);
    mem_load(32'h3F8, 32'h100);
    bus.RETI_REQ = 1;
    @(negedge clk);
    bus.RETI_REQ = 0;
    for (int k = 1; k <= 9; k++) begin
      check_ctl($sformatf("reti_c%0d", k), exp_ctl(2, k));
      if (k == 7) check_val("reti_alu_out", alu_out, 32'h100);
      @(negedge clk);
    end
    check_ctl("reti_idle", exp_ctl(0, 0));
    check_val("reti_sp", sp, 32'h3FC);
    check_val("reti_pc", pc, 32'h100);
    check_val("reti_flags", {27'd0, flags}, 32'h0F);

    // Masking: interrupt blocked by IE=0, then by BOUNDARY=0
    do_reset();
    bus.INTR = 1; bus.BOUNDARY = 1; bus.FLAGS_IE = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) begin bus.FLAGS_IE = 1; bus.BOUNDARY = 0; end
      @(negedge clk);
      check_ctl($sformatf("mask_c%0d", k), exp_ctl(0, 0));
    end

    // RETI and INTR together: RETI first, entry once IDLE is re-entered
    do_reset();
    bus.RETI_REQ = 1; bus.INTR = 1; bus.BOUNDARY = 1; bus.FLAGS_IE = 1;
    @(negedge clk);
    bus.RETI_REQ = 0;
    for (int k = 1; k <= 9; k++) begin
      check_ctl($sformatf("both_reti_c%0d", k), exp_ctl(2, k));
      @(negedge clk);
    end
    check_ctl("both_idle_c10", exp_ctl(0, 0));
    @(negedge clk);
    bus.INTR = 0;
    check_ctl("both_entry_c11", exp_ctl(1, 1));

    // INTR pulse mid-sequence is not latched
    do_reset();
    bus.INTR = 1; bus.BOUNDARY = 1; bus.FLAGS_IE = 1;
    @(negedge clk);
    bus.INTR = 0;
    for (int k = 1; k <= 7; k++) begin
      bus.INTR = (k == 3);
      check_ctl($sformatf("pulse_c%0d", k), exp_ctl(1, k));
      @(negedge clk);
    end
    bus.INTR = 0;
    for (int k = 0; k < 3; k++) begin
      check_ctl($sformatf("pulse_idle%0d", k), exp_ctl(0, 0));
      @(negedge clk);
    end

    // Random requests against a step-count model
    do_reset();
    m_kind = 0;
    m_step = 0;
    for (int c = 0; c < 1500; c++) begin
      check_ctl($sformatf("rand_c%0d", c), exp_ctl(m_kind, m_step));
      rst          = ($urandom_range(0, 63) == 0);
      bus.INTR     = 1'($urandom_range(0, 1));
      bus.BOUNDARY = ($urandom_range(0, 3) != 0);
      bus.FLAGS_IE = ($urandom_range(0, 3) != 0);
      bus.RETI_REQ = ($urandom_range(0, 7) == 0);
      if (rst) begin
        m_kind = 0; m_step = 0;
      end else if (m_kind == 0) begin
        if (bus.RETI_REQ) begin
          m_kind = 2; m_step = 1;
        end else if (bus.INTR && bus.BOUNDARY && bus.FLAGS_IE) begin
          m_kind = 1; m_step = 1;
        end
      end else begin
        m_step++;
        if (m_step > ((m_kind == 1) ? 7 : 9)) begin
          m_kind = 0; m_step = 0;
        end
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/intr_sequencer.md
# intr_sequencer

Microsequencer that drives the integer datapath control fields during interrupt entry and return-from-interrupt (RETI). On an accepted interrupt it pushes PC and the flags word onto the `$sp` stack, then loads the vector. On RETI it pops flags and PC, then restores `$sp`. It sits beside the main MCU. While BUSY is high, the MCU muxes this block's control outputs onto the datapath in place of its own.

## Interface
- FS_ADD, 5'h02, ALU function code for add
- FS_SUB, 5'h03, ALU function code for subtract
- FS_PASS, 5'h00, ALU code driven when idle
- VECTOR, 32'h0000_0200, interrupt handler address driven on PC_VEC
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- INTR  in  1  level interrupt request
- FLAGS_IE  in  1  interrupt-enable bit (FLAGS[4]) from MCU
- BOUNDARY  in  1  MCU is at an instruction boundary
- RETI_REQ  in  1  MCU is decoding RETI (level)
- BUSY  out  1  high in every non-IDLE state
- DONE  out  1  one-cycle pulse in the final state of either sequence
- INTA  out  1  interrupt acknowledge, one-cycle pulse
- IE_CLR  out  1  clear FLAGS[4] in MCU
- FLAGS_LD  out  1  MCU loads flags from datapath FLAGS_OUT
- PC_LD  out  1  MCU PC load strobe
- PC_SRC  out  2  0 = hold, 1 = PC_VEC, 2 = datapath ALU_OUT
- PC_VEC  out  32  constant VECTOR
- FS  out  5  ALU function select
- D_En, S_Sel, T_Sel, HILO_ld  out  1 each  datapath controls; HILO_ld is always 0
- DA_sel, D_Sel  out  2 each  datapath destination and data-out selects
- Y_Sel  out  3  datapath output select
- DT  out  32  immediate fed to the datapath T-mux
- DM_CS, DM_WR, DM_RD  out  1 each  data memory strobes; address = ALU_OUT

## Operation
- Moore FSM. All outputs decode from the registered state only.
- Default (IDLE) output values:
  - FS = FS_PASS, DT = 0.
  - All other controls and strobes = 0.
- Only the fields listed per state differ from the default.
- Stack model: word stack, pre-decrement on push. Regfile writes are synchronous; reads are combinational. Datapath pipeline is RS/RT → ALUReg → write.
- IDLE transitions:
  - RETI_REQ → R_RD1. RETI wins over INTR if both are asserted.
  - Otherwise, BOUNDARY & INTR & FLAGS_IE → E_RD1.
  - Otherwise stay in IDLE.
- Entry sequence:
  - E_RD1: S_Sel=1, T_Sel=1, DT=4.
  - E_ALU1: FS=FS_SUB.
  - E_WR1: DA_sel=3, D_En=1, D_Sel=1, DM_CS=1, DM_WR=1. Result: `$sp` ← `$sp`−4 and mem[`$sp`−4] ← PC.
  - E_RD2: S_Sel=1, T_Sel=1, DT=4.
  - E_ALU2: FS=FS_SUB.
  - E_WR2: DA_sel=3, D_En=1, D_Sel=2, DM_CS=1, DM_WR=1. Pushes the flags word.
  - E_VEC: PC_LD=1, PC_SRC=1, IE_CLR=1, INTA=1, DONE=1 → IDLE.
- RETI sequence:
  - R_RD1: S_Sel=1, T_Sel=1, DT=0.
  - R_ALU1: FS=FS_ADD.
  - R_MEM1: S_Sel=1, DM_CS=1, DM_RD=1, FLAGS_LD=1. Flags are read from mem[`$sp`].
  - R_RD2: S_Sel=1, T_Sel=1, DT=4.
  - R_ALU2: FS=FS_ADD.
  - R_MEM2: DM_CS=1, DM_RD=1. DinReg captures the popped PC.
  - R_PC: Y_Sel=2, PC_LD=1, PC_SRC=2, S_Sel=1, T_Sel=1, DT=8.
  - R_ALU3: FS=FS_ADD.
  - R_WR3: DA_sel=3, D_En=1, DONE=1 → IDLE. Result: `$sp` ← `$sp`+8.
- Requests while BUSY are ignored and not latched. INTR is level, so it is re-sampled in IDLE.
- Undefined state encodings → IDLE on the next edge.

## Timing
- Reset: state=IDLE on the first edge with RESET=1, so every output holds its IDLE value (BUSY=0, INTA=0, DONE=0).
- RESET=1 mid-sequence aborts to IDLE on that edge. No partial stack recovery is performed.
- Acceptance: a request is sampled on edge N; E_RD1 or R_RD1 is active in cycle N+1.
- Entry takes 7 cycles: BUSY is high for cycles N+1..N+7, and INTA/DONE/PC_LD are asserted in cycle N+7.
- RETI takes 9 cycles: PC_LD in cycle N+7, DONE in cycle N+9.
- IDLE is re-entered on the edge after DONE. A new request can be accepted on that same edge's following sample (earliest restart at N+9 for entry, N+11 for RETI).
- DT arithmetic is 32-bit unsigned. `$sp` wraps modulo 2^32 with no detection.

## Test plan
- Reset: hold RESET 2 cycles mid-E_ALU1 → next cycle all outputs at IDLE values, BUSY=0, FS=FS_PASS, DT=0.
- Entry, with `$sp`=0x3FC, PC_in=0x100, FLAGS=5'h1F, INTR=BOUNDARY=1:
  - mem[0x3F8]=0x100 and mem[0x3F4][4:0]=5'h1F.
  - `$sp`=0x3F4.
  - INTA, PC_LD, PC_SRC=1 asserted exactly 7 cycles after acceptance.
- Masking: INTR=1 with FLAGS_IE=0, or BOUNDARY=0, for 20 cycles → BUSY stays 0 and no DM strobes.
- RETI, with `$sp`=0x3F4, mem[0x3F4]=0x0F, mem[0x3F8]=0x100:
  - FLAGS_LD in cycle 3.
  - PC_LD with ALU_OUT=0x100 in cycle 7.
  - `$sp`=0x3FC after DONE in cycle 9.
- Simultaneous RETI_REQ and INTR with IE=1 → RETI runs first. INTR held → entry starts at the first BOUNDARY sampled after return to IDLE.
- INTR pulses during an active sequence (dropped before IDLE) → no second sequence is started.
